// File: rtl/retire_unit_pkg.sv
// Types and widths shared by the retire stage: dispatch classes, retire FSM
// states and the tag/data widths used on the ROB head interface.
package retire_unit_pkg;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    INT    = 3'd0,
    MULT   = 3'd1,
    DIV    = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    BRANCH = 3'd5
  } dispatch_type_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_unit.sv
// In-order retire stage: commits the ROB head to the ARF, drains stores through
// a request/ack handshake and raises a one-cycle flush on branch mispredicts.
module retire_unit
  import retire_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              head_valid,
  input  logic              head_done,
  input  logic [2:0]        head_type,
  input  logic [TAG_W-1:0]  head_tag,
  input  logic [REG_W-1:0]  head_rd,
  input  logic [DATA_W-1:0] head_data,
  input  logic [DATA_W-1:0] head_pc,
  input  logic              head_mispredict,
  input  logic [DATA_W-1:0] head_target,
  input  logic [DATA_W-1:0] head_st_addr,
  input  logic [DATA_W-1:0] head_st_data,
  output logic              retire_pop,
  output logic              arf_wen,
  output logic [REG_W-1:0]  arf_addr,
  output logic [DATA_W-1:0] arf_data,
  output logic              rst_clr_en,
  output logic [REG_W-1:0]  rst_clr_rd,
  output logic [TAG_W-1:0]  rst_clr_tag,
  output logic              st_req,
  output logic [DATA_W-1:0] st_addr,
  output logic [DATA_W-1:0] st_data,
  input  logic              st_ack,
  output logic              flush,
  output logic [DATA_W-1:0] flush_pc,
  output logic [31:0]       retired_cnt
);

  retire_state_e     r_state;
  retire_state_e     w_state_nxt;
  logic              r_st_req;
  logic [DATA_W-1:0] r_st_addr;
  logic [DATA_W-1:0] r_st_data;
  logic              r_flush;
  logic [DATA_W-1:0] r_flush_pc;
  logic [31:0]       r_retired_cnt;

  logic w_head_ok;
  logic w_is_store;
  logic w_is_branch;
  logic w_writes_rd;
  logic w_pop;
  logic w_start_store;
  logic w_store_done;
  logic w_start_flush;

  // The PC is carried on the head interface but retire never needs it.
  logic w_unused_pc;
  assign w_unused_pc = ^head_pc;

  assign w_is_store  = (head_type == STORE);
  assign w_is_branch = (head_type == BRANCH);
  assign w_writes_rd = !w_is_store && !w_is_branch && (head_rd != '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_head_ok     = 1'b0;
    w_pop         = 1'b0;
    w_start_store = 1'b0;
    w_store_done  = 1'b0;
    w_start_flush = 1'b0;
    case (r_state)
      RUN: begin
        w_head_ok = head_valid && head_done;
        if (w_head_ok) begin
          if (w_is_store) begin
            w_start_store = 1'b1;
            w_state_nxt   = ST_WAIT;
          end else begin
            w_pop = 1'b1;
            if (w_is_branch && head_mispredict) begin
              w_start_flush = 1'b1;
              w_state_nxt   = FLUSH;
            end
          end
        end
      end
      ST_WAIT: begin
        if (st_ack) begin
          w_pop        = 1'b1;
          w_store_done = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      FLUSH: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Strobes are gated by reset so nothing leaks out while the FSM is held.
  assign retire_pop  = w_pop && i_rst_n;
  assign arf_wen     = w_head_ok && w_writes_rd && i_rst_n;
  assign rst_clr_en  = w_head_ok && w_writes_rd && i_rst_n;
  assign arf_addr    = head_rd;
  assign arf_data    = head_data;
  assign rst_clr_rd  = head_rd;
  assign rst_clr_tag = head_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= RUN;
      r_st_req      <= 1'b0;
      r_st_addr     <= '0;
      r_st_data     <= '0;
      r_flush       <= 1'b0;
      r_flush_pc    <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_retired_cnt <= r_retired_cnt + 32'(w_pop);
      r_flush       <= w_start_flush;
      if (w_start_flush) r_flush_pc <= head_target;
      if (w_start_store) begin
        r_st_req  <= 1'b1;
        r_st_addr <= head_st_addr;
        r_st_data <= head_st_data;
      end else if (w_store_done) begin
        r_st_req <= 1'b0;
      end
    end
  end

  assign st_req      = r_st_req;
  assign st_addr     = r_st_addr;
  assign st_data     = r_st_data;
  assign flush       = r_flush;
  assign flush_pc    = r_flush_pc;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_retire_unit.sv
// Self-checking bench for retire_unit: directed scenarios then random heads,
// all compared against a transaction-level model of the retire behaviour.
module tb_retire_unit;
  import retire_unit_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        head_valid, head_done, head_mispredict, st_ack;
  logic [2:0]  head_type;
  logic [4:0]  head_tag, head_rd;
  logic [31:0] head_data, head_pc, head_target, head_st_addr, head_st_data;
  logic        retire_pop, arf_wen, rst_clr_en, st_req, flush;
  logic [4:0]  arf_addr, rst_clr_rd, rst_clr_tag;
  logic [31:0] arf_data, st_addr, st_data, flush_pc, retired_cnt;

  always #5 i_clk = ~i_clk;

  retire_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .head_valid(head_valid), .head_done(head_done), .head_type(head_type),
    .head_tag(head_tag), .head_rd(head_rd), .head_data(head_data),
    .head_pc(head_pc), .head_mispredict(head_mispredict),
    .head_target(head_target), .head_st_addr(head_st_addr),
    .head_st_data(head_st_data), .retire_pop(retire_pop),
    .arf_wen(arf_wen), .arf_addr(arf_addr), .arf_data(arf_data),
    .rst_clr_en(rst_clr_en), .rst_clr_rd(rst_clr_rd), .rst_clr_tag(rst_clr_tag),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
    .flush(flush), .flush_pc(flush_pc), .retired_cnt(retired_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: an outstanding store, a pending flush, and a retire count.
  bit          m_store_pend;
  logic [31:0] m_sa, m_sd;
  bit          m_flush;
  logic [31:0] m_fpc;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_store_pend = 0; m_sa = 0; m_sd = 0;
    m_flush = 0; m_fpc = 0; m_cnt = 0;
  endtask

  task automatic set_head(input bit v, input bit d, input int t, input int tag,
                          input int rd, input logic [31:0] data, input bit mp,
                          input logic [31:0] tgt, input logic [31:0] sa,
                          input logic [31:0] sd);
    head_valid = v; head_done = d; head_type = 3'(t); head_tag = 5'(tag);
    head_rd = 5'(rd); head_data = data; head_mispredict = mp;
    head_target = tgt; head_st_addr = sa; head_st_data = sd;
    head_pc = $urandom;
  endtask

  task automatic idle();
    set_head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check one cycle at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit rdy, pop, wen, nflush;
    @(negedge i_clk);
    rdy = !m_store_pend && !m_flush && head_valid && head_done;
    pop = (rdy && head_type != 3'd4) || (m_store_pend && st_ack);
    wen = rdy && head_type <= 3'd3 && head_rd != 0;
    chk("retire_pop", 32'(retire_pop), 32'(pop));
    chk("arf_wen", 32'(arf_wen), 32'(wen));
    chk("rst_clr_en", 32'(rst_clr_en), 32'(wen));
    if (wen) begin
      chk("arf_addr", 32'(arf_addr), 32'(head_rd));
      chk("arf_data", arf_data, head_data);
      chk("rst_clr_rd", 32'(rst_clr_rd), 32'(head_rd));
      chk("rst_clr_tag", 32'(rst_clr_tag), 32'(head_tag));
    end
    chk("st_req", 32'(st_req), 32'(m_store_pend));
    if (m_store_pend) begin
      chk("st_addr", st_addr, m_sa);
      chk("st_data", st_data, m_sd);
    end
    chk("flush", 32'(flush), 32'(m_flush));
    if (m_flush) chk("flush_pc", flush_pc, m_fpc);
    chk("retired_cnt", retired_cnt, m_cnt);
    m_cnt = m_cnt + 32'(pop);
    nflush = rdy && head_type == 3'd5 && head_mispredict;
    if (nflush) m_fpc = head_target;
    if (m_store_pend) begin
      if (st_ack) m_store_pend = 0;
    end else if (rdy && head_type == 3'd4) begin
      m_store_pend = 1; m_sa = head_st_addr; m_sd = head_st_data;
    end
    m_flush = nflush;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    st_ack = 0;
    model_reset();
    set_head(1, 1, INT, 1, 3, 32'h1234, 0, 0, 0, 0);
    #12;
    chk("rst_pop", 32'(retire_pop), 0);
    chk("rst_wen", 32'(arf_wen), 0);
    chk("rst_clr", 32'(rst_clr_en), 0);
    chk("rst_st_req", 32'(st_req), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_cnt", retired_cnt, 0);
    idle();
    @(negedge i_clk); i_rst_n = 1;
    @(posedge i_clk); #1;

    // Plain INT retire and rd=0 retire
    set_head(1, 1, INT, 3, 7, 32'hDEADBEEF, 0, 0, 0, 0);
    step();
    idle(); step();
    chk("int_cnt", retired_cnt, 1);
    set_head(1, 1, INT, 9, 0, 32'hCAFE, 0, 0, 0, 0);
    step();
    idle(); step();

    // Store with ack delayed three cycles
    set_head(1, 1, STORE, 4, 0, 0, 0, 0, 32'h100, 32'h55);
    step();
    for (int i = 0; i < 3; i++) step();
    st_ack = 1; step();
    st_ack = 0; idle(); step();
    chk("store_done_req", 32'(st_req), 0);

    // Mispredicted branch; an INT head waiting during FLUSH must not retire
    set_head(1, 1, BRANCH, 5, 2, 0, 1, 32'h400, 0, 0);
    step();
    set_head(1, 1, INT, 6, 8, 32'h77, 0, 0, 0, 0);
    step();
    step();
    idle(); step();

    // Four back-to-back retires from a fresh count, then counter wrap
    i_rst_n = 0; model_reset(); #2; i_rst_n = 1;
    @(posedge i_clk); #1;
    for (int i = 0; i < 4; i++) begin
      set_head(1, 1, MULT, i, i + 10, 32'(i * 3), 0, 0, 0, 0);
      step();
    end
    idle(); step();
    chk("b2b_cnt", retired_cnt, 4);
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    m_cnt = 32'hFFFF_FFFF;
    set_head(1, 1, LOAD, 1, 1, 32'h1, 0, 0, 0, 0);
    step();
    idle(); step();
    chk("wrap_cnt", retired_cnt, 0);

    // Reset while a store is outstanding
    set_head(1, 1, STORE, 2, 0, 0, 0, 0, 32'h200, 32'h99);
    step();
    idle(); step();
    #2; st_ack = 1; i_rst_n = 0; #1;
    chk("rst_wait_req", 32'(st_req), 0);
    chk("rst_wait_pop", 32'(retire_pop), 0);
    chk("rst_wait_cnt", retired_cnt, 0);
    model_reset();
    @(negedge i_clk); st_ack = 0; #1; i_rst_n = 1;
    @(posedge i_clk); #1;
    step(); step();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      set_head($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 5), $urandom_range(0, 31),
               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31),
               $urandom, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
      st_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
